// File: rtl/fixed_adder_tree_accumulator_if.sv
// fixed_adder_tree_accumulator_if: valid/ready stream bundle carrying partial sums in and accumulated results out
interface fixed_adder_tree_accumulator_if #(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 19
);
    logic [IN_WIDTH-1:0]  data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    logic [OUT_WIDTH-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );
    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/fixed_adder_tree_accumulator.sv
// fixed_adder_tree_accumulator: sums IN_DEPTH consecutive adder-tree partial sums into one full-precision result
module fixed_adder_tree_accumulator #(
    parameter int IN_WIDTH = 17,
    parameter int IN_DEPTH = 4,
    parameter bit SIGNED   = 1'b1
) (
    input logic clk,
    input logic rst_n,
    fixed_adder_tree_accumulator_if.slave bus
);
    localparam int OUT_WIDTH = IN_WIDTH + $clog2(IN_DEPTH);
    localparam int CW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(IN_DEPTH - 1);

    logic [OUT_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0] r_out;
    logic                 r_valid;
    logic [CW-1:0]        r_count;
    logic [OUT_WIDTH-1:0] w_ext;
    logic [OUT_WIDTH-1:0] w_sum;
    logic                 w_last;
    logic                 w_in_ready;
    logic                 w_in_xfer;

    // Extend the beat and fold it into the running sum; a first beat reloads instead of adding
    always_comb begin
        w_ext      = SIGNED ? OUT_WIDTH'($signed(bus.data_in)) : OUT_WIDTH'(bus.data_in);
        w_last     = (r_count == LAST);
        w_sum      = (r_count == '0) ? w_ext : r_acc + w_ext;
        w_in_ready = !w_last || !r_valid || bus.data_out_ready;
        w_in_xfer  = bus.data_in_valid && w_in_ready;
    end

    // Beat counting, accumulation and the output holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_in_xfer && w_last) begin
                r_out   <= w_sum;
                r_count <= '0;
            end else if (w_in_xfer) begin
                r_acc   <= w_sum;
                r_count <= r_count + CW'(1);
            end
            if (w_in_xfer && w_last)
                r_valid <= 1'b1;
            else if (bus.data_out_ready)
                r_valid <= 1'b0;
        end
    end

    assign bus.data_in_ready  = w_in_ready;
    assign bus.data_out       = r_out;
    assign bus.data_out_valid = r_valid;
endmodule
